// File: rtl/rv32i_types.sv
// Shared types for the L2 write buffer.
// Holds the upstream/downstream FSM state enums and the posted-write entry struct.
// Entry data is stored at WB_MAX_WIDTH bits. Users with a narrower data path
// zero-extend on the way in and slice on the way out.
package rv32i_types;

   localparam int unsigned WB_ADDR_W    = 32;
   localparam int unsigned WB_BE_W      = 4;
   localparam int unsigned WB_MAX_WIDTH = 64;

   typedef enum logic [1:0] {
      U_IDLE,
      U_WACK,
      U_RHAZ,
      U_RWAIT
   } up_state_e;

   typedef enum logic [1:0] {
      D_IDLE,
      D_DRAIN,
      D_READ
   } down_state_e;

   typedef struct packed {
      logic [WB_ADDR_W-1:0]    address;
      logic [WB_MAX_WIDTH-1:0] wdata;
      logic [WB_BE_W-1:0]      byte_enable;
   } wb_entry_t;

endpackage

// File: rtl/wb_fifo.sv
// Circular FIFO of posted writes for l2_write_buffer.
// Ports:
//   clk, rst_n              - clock, async active-low reset (clears pointers and count)
//   enq, enq_entry          - push an entry at the tail (caller guarantees not full)
//   deq                     - pop the head entry (caller guarantees not empty)
//   match_addr              - address compared against every valid entry
//   head_entry              - entry at the head pointer
//   count                   - number of valid entries (0..DEPTH)
//   match                   - per-slot hit: slot is valid and its address equals match_addr
module wb_fifo
   import rv32i_types::*;
#(
   parameter int unsigned DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     enq,
   input  wb_entry_t                enq_entry,
   input  logic                     deq,
   input  logic [WB_ADDR_W-1:0]     match_addr,
   output wb_entry_t                head_entry,
   output logic [$clog2(DEPTH):0]   count,
   output logic [DEPTH-1:0]         match
);

   localparam int unsigned PTR_W = $clog2(DEPTH);
   localparam int unsigned CNT_W = PTR_W + 1;

   wb_entry_t          mem [DEPTH];
   logic [PTR_W-1:0]   head_q, head_d;
   logic [PTR_W-1:0]   tail_q, tail_d;
   logic [CNT_W-1:0]   count_q, count_d;

   // DEPTH is a power of two, so plain pointer overflow wraps modulo DEPTH.
   always_comb begin
      head_d  = head_q;
      tail_d  = tail_q;
      count_d = count_q;
      if (enq) tail_d = tail_q + PTR_W'(1);
      if (deq) head_d = head_q + PTR_W'(1);
      unique case ({enq, deq})
         2'b10:   count_d = count_q + CNT_W'(1);
         2'b01:   count_d = count_q - CNT_W'(1);
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         head_q  <= '0;
         tail_q  <= '0;
         count_q <= '0;
      end else begin
         head_q  <= head_d;
         tail_q  <= tail_d;
         count_q <= count_d;
      end
   end

   // Storage needs no reset: slots outside [head, head+count) are never observed.
   always_ff @(posedge clk) begin
      if (enq) mem[tail_q] <= enq_entry;
   end

   // A slot is valid when its distance from head (mod DEPTH) is below count.
   for (genvar i = 0; i < DEPTH; i++) begin : g_match
      logic [PTR_W-1:0] offset;
      assign offset   = PTR_W'(i) - head_q;
      assign match[i] = ({1'b0, offset} < count_q) && (mem[i].address == match_addr);
   end

   assign head_entry = mem[head_q];
   assign count      = count_q;

endmodule

// File: rtl/l2_write_buffer.sv
// Posted write buffer between the arbiter and the L2 cache.
// Writes are acknowledged once buffered and drained in order. Reads bypass
// buffered writes unless a buffered write targets the same address, in which
// case the read waits until that write has drained.
// Ports:
//   clk, rst_n        - clock, async active-low reset
//   up_*              - arbiter side: read/write requests held until up_resp
//   L2cache_*         - L2 side: one read or write request at a time
//   wb_empty          - high when no writes are buffered
module l2_write_buffer
   import rv32i_types::*;
#(
   parameter int unsigned DEPTH = 4,
   parameter int unsigned width = 32
) (
   input  logic                 clk,
   input  logic                 rst_n,
   // upstream
   input  logic                 up_read,
   input  logic                 up_write,
   input  logic [31:0]          up_address,
   input  logic [width-1:0]     up_wdata,
   input  logic [3:0]           up_byte_enable,
   output logic [width-1:0]     up_rdata,
   output logic                 up_resp,
   // downstream
   output logic                 L2cache_read,
   output logic                 L2cache_write,
   output logic [31:0]          L2cache_address,
   output logic [width-1:0]     L2cache_wdata,
   output logic [3:0]           L2cache_byte_enable,
   input  logic [width-1:0]     L2cache_rdata,
   input  logic                 L2cache_resp,
   // status
   output logic                 wb_empty
);

   localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

   up_state_e           u_state_q, u_state_d;
   down_state_e         d_state_q, d_state_d;
   logic                enq, deq;
   wb_entry_t           enq_entry, head_entry;
   logic [CNT_W-1:0]    count;
   logic [DEPTH-1:0]    match;
   logic                hazard, full;

   assign enq_entry = '{address:     up_address,
                        wdata:       WB_MAX_WIDTH'(up_wdata),
                        byte_enable: up_byte_enable};

   wb_fifo #(
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk        (clk),
      .rst_n      (rst_n),
      .enq        (enq),
      .enq_entry  (enq_entry),
      .deq        (deq),
      .match_addr (up_address),
      .head_entry (head_entry),
      .count      (count),
      .match      (match)
   );

   assign hazard   = |match;
   assign full     = (count == CNT_W'(DEPTH));
   assign wb_empty = (count == '0);

   // Upstream FSM: a write wins over a simultaneous read, and a read that hits
   // a buffered write parks in U_RHAZ until the drain removes every match.
   always_comb begin
      u_state_d = u_state_q;
      enq       = 1'b0;
      unique case (u_state_q)
         U_IDLE: begin
            if (up_write) begin
               if (!full) begin
                  enq       = 1'b1;
                  u_state_d = U_WACK;
               end
            end else if (up_read) begin
               u_state_d = hazard ? U_RHAZ : U_RWAIT;
            end
         end
         U_WACK:  u_state_d = U_IDLE;
         U_RHAZ:  if (!hazard) u_state_d = U_RWAIT;
         U_RWAIT: if ((d_state_q == D_READ) && L2cache_resp) u_state_d = U_IDLE;
         default: u_state_d = U_IDLE;
      endcase
   end

   // Downstream FSM: a pending read goes ahead of draining; a started drain
   // always runs to completion.
   always_comb begin
      d_state_d = d_state_q;
      deq       = 1'b0;
      unique case (d_state_q)
         D_IDLE: begin
            if (u_state_q == U_RWAIT) d_state_d = D_READ;
            else if (!wb_empty)       d_state_d = D_DRAIN;
         end
         D_DRAIN: begin
            if (L2cache_resp) begin
               deq       = 1'b1;
               d_state_d = D_IDLE;
            end
         end
         D_READ:  if (L2cache_resp) d_state_d = D_IDLE;
         default: d_state_d = D_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         u_state_q <= U_IDLE;
         d_state_q <= D_IDLE;
      end else begin
         u_state_q <= u_state_d;
         d_state_q <= d_state_d;
      end
   end

   always_comb begin
      L2cache_read        = (d_state_q == D_READ);
      L2cache_write       = (d_state_q == D_DRAIN);
      L2cache_address     = L2cache_read ? up_address : head_entry.address;
      L2cache_wdata       = head_entry.wdata[width-1:0];
      L2cache_byte_enable = L2cache_write ? head_entry.byte_enable : 4'b0000;
      up_rdata            = L2cache_rdata;
      up_resp             = (u_state_q == U_WACK) || (L2cache_read && L2cache_resp);
   end

   if (width < WB_MAX_WIDTH) begin : g_unused_hi
      logic unused_wdata_hi;
      assign unused_wdata_hi = ^head_entry.wdata[WB_MAX_WIDTH-1:width];
   end

endmodule

// File: doc/l2_write_buffer.md
L2_WRITE_BUFFER -- requirements
Module: l2_write_buffer

Interface
REQ-001 Parameter DEPTH, default 4, SHALL set the number of posted-write entries (power of two, 2..16).
REQ-002 Parameter width, default 32, SHALL set the data width.
REQ-003 Clock and reset SHALL be one clock and an asynchronous, active-low reset: clk input 1 is the rising-edge clock; rst_n input 1 is the asynchronous active-low reset.
REQ-004 Upstream ports, from the arbiter side, SHALL be:
- up_read input 1: read request, held until up_resp.
- up_write input 1: write request, held until up_resp.
- up_address input 32: word address.
- up_wdata input width: write data.
- up_byte_enable input 4: write byte mask.
- up_rdata output width: read data.
- up_resp output 1: one-cycle completion pulse.
REQ-005 Downstream ports, to the L2 cache, SHALL be:
- L2cache_read output 1: L2 read request.
- L2cache_write output 1: L2 write request.
- L2cache_address output 32: L2 address.
- L2cache_wdata output width: L2 write data.
- L2cache_byte_enable output 4: L2 byte mask.
- L2cache_rdata input width: L2 read data.
- L2cache_resp input 1: L2 completion pulse.
REQ-006 Status output wb_empty, 1 bit, SHALL be high when no entries are buffered.

Function
REQ-007 Buffer SHALL be a circular FIFO of DEPTH entries {address, wdata, byte_enable} with head/tail pointers and a count of width clog2(DEPTH)+1.
REQ-008 Upstream FSM states SHALL be U_IDLE, U_WACK, U_RHAZ, U_RWAIT.
REQ-009 U_IDLE, up_write=1, count<DEPTH: enqueue at the clock edge, go to U_WACK.
REQ-010 U_IDLE, up_write=1, count=DEPTH: no enqueue, no up_resp, stay in U_IDLE.
REQ-011 U_WACK SHALL assert up_resp for exactly one cycle, then return to U_IDLE, so write latency is 2 cycles from request to resp when not full.
REQ-012 U_IDLE, up_read=1: if any valid entry address equals up_address, go to U_RHAZ; else request the L2 read port and go to U_RWAIT.
REQ-013 U_RHAZ SHALL re-evaluate the match every cycle and go to U_RWAIT once no valid entry matches.
REQ-014 up_write and up_read both high SHALL be treated as a write; the read is never issued.
REQ-015 Downstream FSM states SHALL be D_IDLE, D_DRAIN, D_READ.
REQ-016 D_IDLE transitions SHALL be:
- pending read request has priority: go to D_READ.
- else count>0: go to D_DRAIN.
REQ-017 D_DRAIN SHALL drive L2cache_write=1 with the head entry until L2cache_resp, then dequeue and go to D_IDLE; a drain is never aborted.
REQ-018 D_READ SHALL drive L2cache_read=1 with up_address.
REQ-019 In D_READ, up_resp SHALL equal L2cache_resp combinationally and up_rdata SHALL equal L2cache_rdata; on L2cache_resp both FSMs return to idle.
REQ-020 L2cache_read and L2cache_write SHALL never be high together; both SHALL be low in D_IDLE.
REQ-021 Enqueue and dequeue in the same cycle SHALL leave count unchanged; pointers SHALL wrap modulo DEPTH.
REQ-022 up_rdata SHALL be don't-care outside D_READ; up_resp SHALL be low except in U_WACK and as passed through in D_READ.

Reset
REQ-023 rst_n low SHALL immediately force:
- both FSMs to idle.
- count, head and tail to 0.
- all L2cache_* control outputs and up_resp to 0.
- wb_empty to 1.
REQ-024 Reset mid-drain or mid-read SHALL discard buffered and in-flight transactions; no completion pulse SHALL follow.

Structure
REQ-025 State enums and the entry struct SHALL live in rv32i_types.
REQ-026 The FIFO storage and pointers SHALL be one sub-module, wb_fifo, with an address-match output vector; both FSMs SHALL sit in the top level.

Verification
REQ-027 The bench SHALL cover these directed scenarios:
- Write 0x100/0xDEADBEEF/be=0xF with L2 idle -> up_resp 2 cycles later; L2cache_write with the same values follows; wb_empty returns to 1 after L2cache_resp.
- 4 writes with L2cache_resp held low -> 5th write gets no up_resp until the first drain completes.
- Buffer holds a write to 0x200; read 0x200 -> L2cache_read only after that write drains; read returns the new data.
- Buffer holds a write to 0x200; read 0x300 -> L2cache_read issued before the buffered write drains.
- up_read and up_write high together at 0x40 -> treated as an enqueue only.
- rst_n low during D_DRAIN -> L2cache_write low immediately, wb_empty=1, no up_resp.
